mandel_result_writer: RTL and testbench

- Downstream stage of the engine-result arbiter.
- Accepts granted engine result words (x, y, iteration count) from the shared 27-bit result bus.
- Validates coordinates, computes the linear frame-buffer address x + y*H_RES, maps the iteration count to a pixel value, and buffers results in a small FIFO.
- Drives the frame RAM write port with a valid/ready handshake; counts committed pixels and flags frame completion.

---
 rtl/mandel_result_writer.sv | 233 +++++++++++++++++++++++
 tb/tb_mandel_result_writer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_result_writer.sv
// mandel_result_writer
//   Takes granted engine result words (x, y, iteration count) from the shared
//   result bus. Each word is bounds-checked and registered (S1). It is then
//   turned into a linear frame-buffer address and a pixel value and pushed
//   into a small FIFO (S2). A one-entry output register drives the frame RAM
//   write port with a valid/ready handshake. Committed pixels are counted,
//   and the last pixel of a frame raises a one-cycle frame_done pulse.
//
// Ports
//   clk_iCLK    engine clock, rising edge
//   iRST_N      synchronous active-low reset
//   in_valid    result word present on in_word
//   in_word     [26:17] x, [16:8] y, [7:0] iteration count
//   in_ready    block can take a word this cycle
//   frame_sync  one-cycle pulse at the start of a new frame
//   ram_addr    frame RAM write address (x + y*H_RES)
//   ram_data    pixel value
//   ram_we      write request (valid)
//   ram_ready   RAM accepts the write this cycle
//   pix_count   pixels committed in the current frame
//   frame_done  one-cycle pulse after the H_RES*V_RES-th commit
//   overflow    sticky: a word arrived while in_ready was low
//   oob_err     sticky: an out-of-range coordinate was received
module mandel_result_writer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_ITER   = 255
) (
  input  logic        clk_iCLK,
  input  logic        iRST_N,
  input  logic        in_valid,
  input  logic [26:0] in_word,
  output logic        in_ready,
  input  logic        frame_sync,
  output logic [18:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  input  logic        ram_ready,
  output logic [18:0] pix_count,
  output logic        frame_done,
  output logic        overflow,
  output logic        oob_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [9:0]  X_LIM    = 10'(H_RES);
  localparam logic [8:0]  Y_LIM    = 9'(V_RES);
  localparam logic [7:0]  ITER_LIM = 8'(MAX_ITER);
  localparam logic [18:0] LAST_PIX = 19'(H_RES * V_RES - 1);

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  // Input decode
  logic [9:0] w_x;
  logic [8:0] w_y;
  logic [7:0] w_iter;
  logic       w_in_bounds;
  logic       accept;

  assign w_x    = in_word[26:17];
  assign w_y    = in_word[16:8];
  assign w_iter = in_word[7:0];

  assign w_in_bounds = (w_x < X_LIM) && (w_y < Y_LIM);
  assign accept      = in_valid & in_ready;

  // S1 register
  logic       s1_valid;
  logic [9:0] s1_x;
  logic [8:0] s1_y;
  logic [7:0] s1_iter;

  // The bounds check is made as the word enters S1, so an out-of-range word
  // never occupies S1 and never holds back in_ready.
  always_ff @(posedge clk_iCLK) begin
    if (!iRST_N) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_iter  <= '0;
    end else begin
      s1_valid <= accept & w_in_bounds;
      if (accept) begin
        s1_x    <= w_x;
        s1_y    <= w_y;
        s1_iter <= w_iter;
      end
    end
  end

  // S2: address and pixel mapping
  logic [18:0] s2_addr;
  logic [7:0]  s2_data;

  always_comb begin
    s2_addr = 19'(s1_x) + 19'(s1_y) * 19'(H_RES);
    s2_data = (s1_iter >= ITER_LIM) ? '0 : s1_iter;
  end

  // Result FIFO
  logic [26:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign push       = s1_valid;
  assign fifo_empty = (fifo_count == '0);

  // S1 plus FIFO never hold more than FIFO_DEPTH words, so a valid S1 always
  // finds a free slot.
  assign in_ready = (fifo_count + CW'(s1_valid)) < CW'(FIFO_DEPTH);

  always_ff @(posedge clk_iCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {s2_addr, s2_data};
    end
  end

  always_ff @(posedge clk_iCLK) begin
    if (!iRST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output register
  out_state_t state;
  out_state_t next_state;
  logic       commit;

  assign ram_we = (state == OUT_FULL);
  assign commit = ram_we & ram_ready;

  always_ff @(posedge clk_iCLK) begin
    if (!iRST_N) begin
      state <= OUT_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    unique case (state)
      OUT_EMPTY: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = OUT_FULL;
        end
      end
      OUT_FULL: begin
        // Refill on the commit edge keeps writes back-to-back.
        if (commit) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            next_state = OUT_EMPTY;
          end
        end
      end
      default: next_state = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk_iCLK) begin
    if (!iRST_N) begin
      ram_addr <= '0;
      ram_data <= '0;
    end else if (pop) begin
      {ram_addr, ram_data} <= fifo_mem[rd_ptr];
    end
  end

  // Pixel counter and frame completion
  always_ff @(posedge clk_iCLK) begin
    if (!iRST_N) begin
      pix_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_sync) begin
        // A commit on the sync edge is the first pixel of the new frame.
        pix_count <= commit ? 19'd1 : 19'd0;
      end else if (commit) begin
        if (pix_count == LAST_PIX) begin
          pix_count  <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_count <= pix_count + 19'd1;
        end
      end
    end
  end

  // Sticky error flags
  always_ff @(posedge clk_iCLK) begin
    if (!iRST_N) begin
      overflow <= 1'b0;
      oob_err  <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      if (accept && !w_in_bounds) begin
        oob_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mandel_result_writer.sv
// Directed bench for mandel_result_writer. A default-sized instance covers
// addressing, stall/overflow, frame_sync and reset. A second instance with an
// 8x4 frame covers the frame wrap within a short run. Both instances share
// the same input stimulus.
module tb_mandel_result_writer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [26:0] in_word;
  logic        frame_sync;
  logic        ram_ready;

  logic        in_ready;
  logic [18:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic [18:0] pix_count;
  logic        frame_done;
  logic        overflow;
  logic        oob_err;

  logic        s_in_ready;
  logic [18:0] s_ram_addr;
  logic [7:0]  s_ram_data;
  logic        s_ram_we;
  logic [18:0] s_pix_count;
  logic        s_frame_done;
  logic        s_overflow;
  logic        s_oob_err;

  int checks = 0;
  int errors = 0;

  mandel_result_writer dut (
    .clk_iCLK  (clk),
    .iRST_N    (rst_n),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (in_ready),
    .frame_sync(frame_sync),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .ram_ready (ram_ready),
    .pix_count (pix_count),
    .frame_done(frame_done),
    .overflow  (overflow),
    .oob_err   (oob_err)
  );

  mandel_result_writer #(
    .H_RES     (8),
    .V_RES     (4),
    .FIFO_DEPTH(4),
    .MAX_ITER  (100)
  ) dut_s (
    .clk_iCLK  (clk),
    .iRST_N    (rst_n),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (s_in_ready),
    .frame_sync(frame_sync),
    .ram_addr  (s_ram_addr),
    .ram_data  (s_ram_data),
    .ram_we    (s_ram_we),
    .ram_ready (ram_ready),
    .pix_count (s_pix_count),
    .frame_done(s_frame_done),
    .overflow  (s_overflow),
    .oob_err   (s_oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] mk(input int unsigned x, input int unsigned y,
                                     input int unsigned it);
    return {x[9:0], y[8:0], it[7:0]};
  endfunction

  initial begin
    int we_seen;
    int exp_pix;
    int idx;
    logic exp_we;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_word    = '0;
    frame_sync = 1'b0;
    ram_ready  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_pix", pix_count, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_ready", in_ready, 1);

    // Single word: x=5 y=2 -> 5 + 2*640 = 1285, three-cycle latency
    in_valid = 1'b1;
    in_word  = mk(5, 2, 17);
    tick();
    in_valid = 1'b0;
    chk("lat_we_e0", ram_we, 0);
    tick();
    chk("lat_we_e1", ram_we, 0);
    tick();
    chk("lat_we_e2", ram_we, 1);
    chk("lat_addr", ram_addr, 1285);
    chk("lat_data", ram_data, 17);
    tick();
    chk("lat_pix", pix_count, 1);
    chk("lat_we_done", ram_we, 0);

    // Last pixel of the frame, iteration at MAX_ITER maps to 0
    in_valid = 1'b1;
    in_word  = mk(639, 479, 255);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("max_we", ram_we, 1);
    chk("max_addr", ram_addr, 307199);
    chk("max_data", ram_data, 0);
    tick();
    chk("max_pix", pix_count, 2);

    // Out of range x
    in_valid = 1'b1;
    in_word  = mk(640, 0, 1);
    tick();
    in_valid = 1'b0;
    chk("oob_flag", oob_err, 1);
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ram_we) we_seen++;
    end
    chk("oob_nowrite", we_seen, 0);
    chk("oob_pix", pix_count, 2);
    chk("oob_ovf", overflow, 0);

    // Stall: word 0 sits in the output register, S1 + FIFO take 8 more,
    // so words 0..8 are held and 9..11 are dropped.
    ram_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_word  = mk(i + 10, 3, i + 1);
      chk("stall_ready", in_ready, (i <= 8) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    chk("stall_we", ram_we, 1);
    chk("stall_addr0", ram_addr, 1930);
    chk("stall_data0", ram_data, 1);
    tick();
    tick();
    chk("stall_hold_addr", ram_addr, 1930);
    chk("stall_hold_data", ram_data, 1);
    chk("stall_ovf", overflow, 1);
    chk("stall_full", in_ready, 0);
    ram_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      chk("drain_we", ram_we, 1);
      chk("drain_addr", ram_addr, 1930 + j);
      chk("drain_data", ram_data, j + 1);
      tick();
    end
    chk("drain_end_we", ram_we, 0);
    chk("drain_pix", pix_count, 11);

    // frame_sync on the commit edge
    in_valid = 1'b1;
    in_word  = mk(1, 1, 200);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sync_we", ram_we, 1);
    chk("sync_addr", ram_addr, 641);
    chk("sync_data", ram_data, 200);
    chk("sync_pix_pre", pix_count, 11);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("sync_pix", pix_count, 1);
    chk("sync_fdone", frame_done, 0);
    tick();
    chk("sync_fdone2", frame_done, 0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("sync_clear", pix_count, 0);
    chk("sync_ovf_sticky", overflow, 1);
    chk("sync_oob_sticky", oob_err, 1);

    // Reset clears sticky flags
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_ovf", overflow, 0);
    chk("rst2_oob", oob_err, 0);

    // Full 8x4 frame on the small instance: accepts at edges 0..31,
    // writes during cycles 2..33, commits on edges 3..34.
    for (int c = 0; c < 40; c++) begin
      in_valid = (c < 32);
      in_word  = mk(c % 8, c / 8, c * 4);
      tick();
      exp_we = (c >= 2 && c <= 33);
      chk("frm_we", s_ram_we, exp_we);
      if (exp_we) begin
        idx = c - 2;
        chk("frm_addr", s_ram_addr, idx);
        chk("frm_data", s_ram_data, (idx * 4 >= 100) ? 0 : idx * 4);
      end
      exp_pix = (c < 3) ? 0 : ((c <= 33) ? c - 2 : 0);
      chk("frm_pix", s_pix_count, exp_pix);
      chk("frm_fdone", s_frame_done, (c == 34) ? 1 : 0);
    end

    // Reset with words buffered
    ram_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_word  = mk(i, 0, i);
      tick();
    end
    in_word = mk(700, 0, 0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("buf_we", ram_we, 1);
    chk("buf_oob", oob_err, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst3_we", ram_we, 0);
    chk("rst3_addr", ram_addr, 0);
    chk("rst3_data", ram_data, 0);
    chk("rst3_pix", pix_count, 0);
    chk("rst3_fdone", frame_done, 0);
    chk("rst3_oob", oob_err, 0);
    chk("rst3_ovf", overflow, 0);
    chk("rst3_ready", in_ready, 1);
    chk("rst3_s_oob", s_oob_err, 0);
    ram_ready = 1'b1;
    we_seen   = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ram_we || s_ram_we) we_seen++;
    end
    chk("rst3_nowrite", we_seen, 0);
    chk("rst3_pix_after", pix_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
